// File: rtl/media_notas_pkg.sv
// Shared types and display patterns for the grade-averaging block.
// The FSM state enum and the 7-segment letter codes live here.
package media_notas_pkg;

  typedef enum logic [1:0] {COLLECT, DIVIDE, SHOW} estado_t;

  localparam logic [7:0] SEG_A    = 8'b01110111;
  localparam logic [7:0] SEG_F    = 8'b01110001;
  localparam logic [7:0] SEG_P    = 8'b01110011;
  localparam logic [7:0] SEG_DASH = 8'b01000000;

endpackage

// File: rtl/media_notas_if.sv
// Switch inputs and display/status outputs of media_notas.
// The master side drives the switches and the slave side is the averager.
interface media_notas_if #(
  parameter int NBITS_NOTA = 4,
  parameter int NGRADES    = 4
);
  localparam int NBITS_CNT = $clog2(NGRADES + 1);

  logic [NBITS_NOTA-1:0] nota_in;
  logic                  enter;
  logic                  calc;
  logic [7:0]            SEG;
  logic [NBITS_CNT-1:0]  count;
  logic [NBITS_NOTA-1:0] media;
  logic                  busy;
  logic                  valid;

  modport master (
    output nota_in, enter, calc,
    input  SEG, count, media, busy, valid
  );

  modport slave (
    input  nota_in, enter, calc,
    output SEG, count, media, busy, valid
  );
endinterface

// File: rtl/div_restaurador.sv
// Restoring divider: one quotient bit per cycle, MSB first, NBITS_SUM steps.
// done and quotient describe the step finishing on the current edge.
module div_restaurador #(
  parameter int NBITS_SUM = 7,
  parameter int NBITS_CNT = 3
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NBITS_SUM-1:0] dividend,
  input  logic [NBITS_CNT-1:0] divisor,
  output logic [NBITS_SUM-1:0] quotient,
  output logic                 busy,
  output logic                 done
);
  localparam int NBITS_IT = $clog2(NBITS_SUM);

  logic [NBITS_IT-1:0]  iter;
  logic [NBITS_CNT-1:0] rem;
  logic [NBITS_CNT-1:0] rem_next;
  logic [NBITS_SUM-2:0] quo;
  logic [NBITS_CNT:0]   trial;
  logic                 q_bit;

  // The partial remainder is always below the divisor, so it fits NBITS_CNT bits.
  always_comb begin
    trial    = {rem, dividend[iter]};
    q_bit    = (trial >= {1'b0, divisor});
    rem_next = trial[NBITS_CNT-1:0];
    if (q_bit) begin
      rem_next = NBITS_CNT'(trial - {1'b0, divisor});
    end
  end

  assign quotient = {quo, q_bit};
  assign done     = busy && (iter == '0);

  always_ff @(posedge clk_2) begin
    if (reset) begin
      busy <= 1'b0;
      iter <= '0;
      rem  <= '0;
      quo  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      iter <= NBITS_IT'(NBITS_SUM - 1);
      rem  <= '0;
      quo  <= '0;
    end else if (busy) begin
      rem  <= rem_next;
      quo  <= quotient[NBITS_SUM-2:0];
      iter <= iter - NBITS_IT'(1);
      if (iter == '0) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/media_notas.sv
// Collects a batch of grades, averages them with div_restaurador and shows
// the A/F/P letter for the average on the 7-segment display.
module media_notas
  import media_notas_pkg::*;
#(
  parameter int NBITS_NOTA = 4,
  parameter int NGRADES    = 4,
  parameter int LIM_A      = 7,
  parameter int LIM_F      = 4
) (
  input  logic            clk_2,
  input  logic            reset,
  media_notas_if.slave    bus
);
  localparam int NBITS_CNT = $clog2(NGRADES + 1);
  localparam int NBITS_SUM = NBITS_NOTA + NBITS_CNT;
  localparam logic [NBITS_CNT-1:0] FULL = NBITS_CNT'(NGRADES);

  estado_t               state;
  estado_t               state_next;
  logic                  enter_q;
  logic                  calc_q;
  logic                  enter_p;
  logic                  calc_p;
  logic                  add;
  logic                  close;
  logic [NBITS_SUM-1:0]  sum;
  logic [NBITS_CNT-1:0]  count_r;
  logic [NBITS_NOTA-1:0] media_r;
  logic [NBITS_SUM-1:0]  quotient;
  logic                  div_busy;
  logic                  div_done;

  assign enter_p = bus.enter & ~enter_q;
  assign calc_p  = bus.calc & ~calc_q;
  assign add     = (state == COLLECT) && enter_p && (count_r < FULL);
  // A grade arriving with calc is counted before the batch closes.
  assign close   = (state == COLLECT) &&
                   ((count_r == FULL) || (calc_p && ((count_r != '0) || add)));

  div_restaurador #(
    .NBITS_SUM (NBITS_SUM),
    .NBITS_CNT (NBITS_CNT)
  ) u_div (
    .clk_2    (clk_2),
    .reset    (reset),
    .start    (close),
    .dividend (sum),
    .divisor  (count_r),
    .quotient (quotient),
    .busy     (div_busy),
    .done     (div_done)
  );

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (close)    state_next = DIVIDE;
      DIVIDE:  if (div_done) state_next = SHOW;
      SHOW:    if (enter_p)  state_next = COLLECT;
      default:               state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      enter_q <= 1'b0;
      calc_q  <= 1'b0;
      sum     <= '0;
      count_r <= '0;
      media_r <= '0;
    end else begin
      enter_q <= bus.enter;
      calc_q  <= bus.calc;
      if (add) begin
        sum     <= sum + NBITS_SUM'(bus.nota_in);
        count_r <= count_r + NBITS_CNT'(1);
      end else if ((state == SHOW) && enter_p) begin
        sum     <= NBITS_SUM'(bus.nota_in);
        count_r <= NBITS_CNT'(1);
      end
      if (div_done) begin
        media_r <= (|quotient[NBITS_SUM-1:NBITS_NOTA]) ? '1 : quotient[NBITS_NOTA-1:0];
      end
    end
  end

  always_comb begin
    bus.SEG   = SEG_DASH;
    bus.valid = 1'b0;
    if (state == SHOW) begin
      bus.valid = 1'b1;
      if (int'(media_r) >= LIM_A) begin
        bus.SEG = SEG_A;
      end else if (int'(media_r) >= LIM_F) begin
        bus.SEG = SEG_F;
      end else begin
        bus.SEG = SEG_P;
      end
    end
  end

  assign bus.count = count_r;
  assign bus.media = media_r;
  assign bus.busy  = div_busy;

endmodule

// File: tb/tb_media_notas.sv
// Self-checking bench for media_notas: vector table, hand-written corner
// sequences and random batches scored against a plain-arithmetic model.
module tb_media_notas;
  import media_notas_pkg::*;

  localparam int NOTA_W = 4;
  localparam int NG     = 4;
  localparam int LA     = 7;
  localparam int LF     = 4;
  localparam int NSUM   = NOTA_W + $clog2(NG + 1);

  typedef struct {
    int n;
    int g0, g1, g2, g3;
    bit useCalc;
    int expMedia;
    int expSeg;
  } vec_t;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lastMedia = 0;
  bit   inShow = 1'b0;
  int   batch[$];
  vec_t vecs[9];

  media_notas_if #(.NBITS_NOTA(NOTA_W), .NGRADES(NG)) bus();

  media_notas #(
    .NBITS_NOTA (NOTA_W),
    .NGRADES    (NG),
    .LIM_A      (LA),
    .LIM_F      (LF)
  ) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int nota, input bit en, input bit ca);
    bus.nota_in = NOTA_W'(nota);
    bus.enter   = en;
    bus.calc    = ca;
    tick();
  endtask

  task automatic enterGrade(input int g);
    applyStimulus(g, 1'b1, 1'b0);
    applyStimulus(g, 1'b0, 1'b0);
  endtask

  function automatic int refMedia();
    int s = 0;
    foreach (batch[i]) s += batch[i];
    return s / batch.size();
  endfunction

  function automatic int refSeg(input int avg);
    if (avg >= LA) return int'(SEG_A);
    if (avg >= LF) return int'(SEG_F);
    return int'(SEG_P);
  endfunction

  task automatic waitShow(input int expMedia, input int expSeg, input int expBusy, input string tag);
    int busyCnt = 0;
    bit seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busyCnt++;
      tick();
    end
    checkOutput({tag, "_valid_seen"}, int'(seen), 1);
    checkOutput({tag, "_busy_cycles"}, busyCnt, expBusy);
    checkOutput({tag, "_media"}, int'(bus.media), expMedia);
    checkOutput({tag, "_seg"}, int'(bus.SEG), expSeg);
    checkOutput({tag, "_busy_low"}, int'(bus.busy), 0);
    lastMedia = expMedia;
    inShow = 1'b1;
  endtask

  task automatic runBatch(input bit useCalc, input int expMedia, input int expSeg, input string tag);
    for (int i = 0; i < batch.size(); i++) begin
      applyStimulus(batch[i], 1'b1, 1'b0);
      bus.enter = 1'b0;
      if (i == 0 && inShow) begin
        checkOutput({tag, "_new_valid"}, int'(bus.valid), 0);
        checkOutput({tag, "_new_seg"}, int'(bus.SEG), int'(SEG_DASH));
        checkOutput({tag, "_new_media_held"}, int'(bus.media), lastMedia);
      end
      tick();
      checkOutput($sformatf("%s_count%0d", tag, i + 1), int'(bus.count), i + 1);
    end
    inShow = 1'b0;
    if (useCalc) begin
      applyStimulus(0, 1'b0, 1'b1);
      bus.calc = 1'b0;
    end
    waitShow(expMedia, expSeg, NSUM, tag);
  endtask

  initial begin
    vecs[0] = '{2, 5, 4, 0, 0, 1'b1, 4, int'(SEG_F)};
    vecs[1] = '{4, 8, 9, 7, 6, 1'b0, 7, int'(SEG_A)};
    vecs[2] = '{4, 1, 2, 3, 3, 1'b0, 2, int'(SEG_P)};
    vecs[3] = '{1, 4, 0, 0, 0, 1'b1, 4, int'(SEG_F)};
    vecs[4] = '{2, 2, 5, 0, 0, 1'b1, 3, int'(SEG_P)};
    vecs[5] = '{1, 7, 0, 0, 0, 1'b1, 7, int'(SEG_A)};
    vecs[6] = '{2, 6, 7, 0, 0, 1'b1, 6, int'(SEG_F)};
    vecs[7] = '{3, 0, 0, 0, 0, 1'b1, 0, int'(SEG_P)};
    vecs[8] = '{4, 15, 15, 14, 15, 1'b0, 14, int'(SEG_A)};

    bus.nota_in = '0;
    bus.enter   = 1'b0;
    bus.calc    = 1'b0;

    // Reset values
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_seg", int'(bus.SEG), int'(SEG_DASH));
    checkOutput("rst_count", int'(bus.count), 0);
    checkOutput("rst_media", int'(bus.media), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_valid", int'(bus.valid), 0);

    // calc with an empty batch must not start a division
    applyStimulus(0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0);
    tick();
    checkOutput("calc_empty_busy", int'(bus.busy), 0);
    checkOutput("calc_empty_seg", int'(bus.SEG), int'(SEG_DASH));
    checkOutput("calc_empty_count", int'(bus.count), 0);

    // enter held high counts once
    bus.nota_in = 4'd9;
    bus.enter   = 1'b1;
    repeat (5) tick();
    applyStimulus(9, 1'b0, 1'b0);
    checkOutput("held_count", int'(bus.count), 1);
    checkOutput("held_busy", int'(bus.busy), 0);
    applyStimulus(0, 1'b0, 1'b1);
    bus.calc = 1'b0;
    waitShow(9, int'(SEG_A), NSUM, "held");

    foreach (vecs[v]) begin
      batch = {vecs[v].g0, vecs[v].g1, vecs[v].g2, vecs[v].g3};
      while (batch.size() > vecs[v].n) void'(batch.pop_back());
      runBatch(vecs[v].useCalc, vecs[v].expMedia, vecs[v].expSeg, $sformatf("vec%0d", v));
    end

    // Fifth enter arrives during DIVIDE and is ignored
    repeat (4) enterGrade(15);
    enterGrade(3);
    checkOutput("fifth_count", int'(bus.count), 4);
    checkOutput("fifth_busy", int'(bus.busy), 1);
    waitShow(15, int'(SEG_A), NSUM - 2, "fifth");

    // Grade and calc on the same cycle: grade is counted first
    enterGrade(6);
    applyStimulus(9, 1'b1, 1'b1);
    bus.enter = 1'b0;
    bus.calc  = 1'b0;
    checkOutput("simul_count", int'(bus.count), 2);
    waitShow(7, int'(SEG_A), NSUM, "simul");

    // Reset during the third DIVIDE cycle
    repeat (4) enterGrade(8);
    tick();
    tick();
    checkOutput("midrst_busy_before", int'(bus.busy), 1);
    reset = 1'b1;
    tick();
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_valid", int'(bus.valid), 0);
    checkOutput("midrst_count", int'(bus.count), 0);
    checkOutput("midrst_media", int'(bus.media), 0);
    checkOutput("midrst_seg", int'(bus.SEG), int'(SEG_DASH));
    reset = 1'b0;
    tick();
    tick();
    checkOutput("midrst_idle_busy", int'(bus.busy), 0);
    checkOutput("midrst_idle_valid", int'(bus.valid), 0);
    lastMedia = 0;
    inShow = 1'b0;

    // Random batches against the arithmetic model
    for (int r = 0; r < 15; r++) begin
      int n;
      n = int'($urandom_range(1, NG));
      batch = {};
      for (int k = 0; k < n; k++) batch.push_back(int'($urandom_range(0, 15)));
      runBatch(n < NG, refMedia(), refSeg(refMedia()), $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/media_notas.md
# media_notas

Sequential successor to the single-grade A/F/P classifier on the lab board. It collects up to NGRADES unsigned grades from the switches, one per rising edge of an enter switch. It computes their integer average with a fixed-latency restoring divider and drives the 7-segment display with the letter for that average. Grade width, batch depth and both thresholds are parameters.

## Interface
- NBITS_NOTA, 4: grade width in bits (unsigned).
- NGRADES, 4: grades per batch (≥1).
- LIM_A, 7: average ≥ LIM_A displays A.
- LIM_F, 4: average ≥ LIM_F (and < LIM_A) displays F; below displays P.
- Derived: NBITS_CNT = $clog2(NGRADES+1); NBITS_SUM = NBITS_NOTA + NBITS_CNT.
- clk_2  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- nota_in  in  NBITS_NOTA  grade from switches, sampled on an enter edge.
- enter  in  1  level switch; each 0→1 transition adds one grade.
- calc  in  1  level switch; a 0→1 transition closes a partial batch.
- SEG  out  8  7-segment pattern: A=8'b01110111, F=8'b01110001, P=8'b01110011, dash=8'b01000000.
- count  out  NBITS_CNT  grades accumulated in the current batch.
- media  out  NBITS_NOTA  last computed average, floor(sum/count).
- busy  out  1  divider running.
- valid  out  1  media/SEG letter belong to a finished batch.

## Operation
- Edge detection: enter_q/calc_q registered each cycle. enter_p = enter & ~enter_q; calc_p = calc & ~calc_q.
- Reset values: state COLLECT, sum=0, count=0, media=0, busy=0, valid=0, SEG=dash, enter_q=calc_q=0.
- COLLECT:
  - On enter_p with count<NGRADES: sum += nota_in, count += 1.
  - enter_p with count==NGRADES is ignored.
  - Leave for DIVIDE when count==NGRADES, or on calc_p with count≠0. calc_p with count==0 is ignored.
  - SEG=dash.
- DIVIDE:
  - Restoring divide of sum by count; one quotient bit per cycle, MSB first, NBITS_SUM cycles.
  - busy=1. enter_p and calc_p are ignored.
  - Quotient always fits NBITS_NOTA, because the average is ≤ the max grade.
  - Then go to SHOW.
- SHOW:
  - valid=1; media holds the quotient; SEG = A/F/P per LIM_A/LIM_F, compared unsigned.
  - enter_p starts a new batch: sum=nota_in, count=1, valid=0, state COLLECT.
  - calc_p is ignored.
- Sum width NBITS_SUM guarantees no overflow (max NGRADES·(2^NBITS_NOTA−1)).

## Timing
- Grade accumulation: enter rising at edge t → sum/count updated at edge t (1-cycle latency from the sampled edge).
- Batch close: the cycle after count reaches NGRADES (or the cycle calc_p is seen) the FSM enters DIVIDE.
- Division: busy high for exactly NBITS_SUM cycles. valid and SEG letter appear on the edge ending the last divide step.
- Enter held high any number of cycles counts once. Simultaneous enter_p and calc_p in COLLECT: the grade is added first, then the batch closes with the new count.
- Reset has priority over everything, including mid-DIVIDE. All outputs return to reset values on the next edge.
- media is held unchanged from SHOW through the next COLLECT until the next division completes. valid drops when the new batch starts.

## Structure
- Package media_notas_pkg holds:
  - typedef enum {COLLECT, DIVIDE, SHOW} estado_t;
  - SEG constants SEG_A, SEG_F, SEG_P, SEG_DASH.
- Sub-module div_restaurador (params NBITS_SUM, NBITS_CNT): start/dividend/divisor in; quotient/busy/done out. It holds the iteration counter and partial remainder.
- media_notas owns the edge detectors, accumulator, FSM and letter decode.

## Test plan
Defaults throughout: NBITS_SUM=7.
- Grades 8,9,7,6 entered with clean enter pulses → count=4, DIVIDE 7 cycles busy, then media=7, valid=1, SEG=A.
- Grades 5,4 then calc pulse → media=4 (9/2), SEG=F. Grades 1,2,3,3 → media=2, SEG=P.
- enter held high 5 cycles with nota_in=9 → count=1, sum=9. calc pulse with count=0 → stays COLLECT, SEG=dash.
- Four grades of 15 → sum=60, no overflow, media=15, SEG=A. A fifth enter before DIVIDE is ignored.
- reset asserted on the 3rd DIVIDE cycle → next edge: busy=0, valid=0, count=0, media=0, SEG=dash.
- In SHOW, enter_p with nota_in=3 → count=1, valid=0, SEG=dash, media keeps the previous value.
